// File: rtl/decode_stage.sv
// RV32I decode stage: raw words queue in a small FIFO behind a valid/ready handshake and the
// head is decoded into an output register that holds steady while the consumer stalls.
module decode_stage #(
    parameter int DEPTH = 2,
    parameter int RV32E = 0
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       instr_valid_i,
    output logic                       instr_ready_o,
    input  logic [31:0]                instr_rdata_i,
    input  logic                       flush_i,
    output logic                       dec_valid_o,
    input  logic                       dec_ready_i,
    output logic [31:0]                imm_o,
    output logic                       req_rf_ra_o,
    output logic                       req_rf_rb_o,
    output logic [4:0]                 rf_raddr_a_o,
    output logic [4:0]                 rf_raddr_b_o,
    output logic [4:0]                 rf_waddr_o,
    output logic                       req_alu_o,
    output logic [4:0]                 operateur_alu_o,
    output logic                       type_operand_b_o,
    output logic                       req_pc_alu_o,
    output logic [1:0]                 operateur_pc_alu_o,
    output logic                       req_data_o,
    output logic                       we_data_o,
    output logic                       illegal_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    typedef struct packed {
        logic [31:0] imm;
        logic        req_ra;
        logic        req_rb;
        logic [4:0]  raddr_a;
        logic [4:0]  raddr_b;
        logic [4:0]  waddr;
        logic        req_alu;
        logic [4:0]  alu_op;
        logic        op_b;
        logic        req_pc;
        logic [1:0]  pc_op;
        logic        req_data;
        logic        we_data;
        logic        illegal;
    } dec_t;

    logic [31:0]      mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_next_s;
    logic             dec_valid_r;
    dec_t             dec_r;
    dec_t             dec_s;
    logic             ready_s;
    logic             push_s;
    logic             load_s;
    logic             head_avail_s;
    logic             src_avail_s;
    logic             fifo_push_s;
    logic             fifo_pop_s;
    logic [31:0]      src_word_s;

    function automatic logic [31:0] imm_i(input logic [31:0] w);
        return {{20{w[31]}}, w[31:20]};
    endfunction

    function automatic logic [31:0] imm_s(input logic [31:0] w);
        return {{20{w[31]}}, w[31:25], w[11:7]};
    endfunction

    function automatic logic [31:0] imm_b(input logic [31:0] w);
        return {{19{w[31]}}, w[31], w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] imm_u(input logic [31:0] w);
        return {w[31:12], 12'h000};
    endfunction

    function automatic logic [31:0] imm_j(input logic [31:0] w);
        return {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
    endfunction

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PTR_W'(1);
    endfunction

    // An illegal word collapses to illegal=1 with every other field zero so nothing downstream fires.
    function automatic dec_t decode_word(input logic [31:0] w);
        dec_t       d;
        logic [2:0] f3;
        logic       bad;
        d   = '0;
        f3  = w[14:12];
        bad = 1'b0;
        case (w[6:0])
            OPC_LUI: begin
                d.imm     = imm_u(w);
                d.req_alu = 1'b1;
                d.alu_op  = 5'b11000;
                d.op_b    = 1'b1;
                d.waddr   = w[11:7];
            end
            OPC_AUIPC: begin
                d.imm    = imm_u(w);
                d.req_pc = 1'b1;
                d.pc_op  = 2'b11;
                d.waddr  = w[11:7];
            end
            OPC_JAL: begin
                d.imm    = imm_j(w);
                d.req_pc = 1'b1;
                d.pc_op  = 2'b00;
                d.waddr  = w[11:7];
            end
            OPC_JALR: begin
                bad       = (f3 != 3'b000);
                d.imm     = imm_i(w);
                d.req_pc  = 1'b1;
                d.pc_op   = 2'b01;
                d.req_ra  = 1'b1;
                d.raddr_a = w[19:15];
                d.waddr   = w[11:7];
            end
            OPC_BRANCH: begin
                bad       = (f3 == 3'b010) || (f3 == 3'b011);
                d.imm     = imm_b(w);
                d.req_pc  = 1'b1;
                d.pc_op   = 2'b10;
                d.req_alu = 1'b1;
                d.alu_op  = {2'b10, f3};
                d.req_ra  = 1'b1;
                d.req_rb  = 1'b1;
                d.raddr_a = w[19:15];
                d.raddr_b = w[24:20];
            end
            OPC_LOAD: begin
                bad        = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
                d.imm      = imm_i(w);
                d.req_data = 1'b1;
                d.req_alu  = 1'b1;
                d.alu_op   = 5'b00000;
                d.op_b     = 1'b1;
                d.req_ra   = 1'b1;
                d.raddr_a  = w[19:15];
                d.waddr    = w[11:7];
            end
            OPC_STORE: begin
                bad        = (f3 > 3'b010);
                d.imm      = imm_s(w);
                d.req_data = 1'b1;
                d.we_data  = 1'b1;
                d.req_alu  = 1'b1;
                d.alu_op   = 5'b00000;
                d.op_b     = 1'b1;
                d.req_ra   = 1'b1;
                d.req_rb   = 1'b1;
                d.raddr_a  = w[19:15];
                d.raddr_b  = w[24:20];
            end
            OPC_OPIMM: begin
                d.imm     = imm_i(w);
                d.req_alu = 1'b1;
                d.alu_op  = {1'b0, w[30] & (f3 == 3'b101), f3};
                d.op_b    = 1'b1;
                d.req_ra  = 1'b1;
                d.raddr_a = w[19:15];
                d.waddr   = w[11:7];
            end
            OPC_OP: begin
                d.req_alu = 1'b1;
                d.alu_op  = {1'b0, w[30], f3};
                d.op_b    = 1'b0;
                d.req_ra  = 1'b1;
                d.req_rb  = 1'b1;
                d.raddr_a = w[19:15];
                d.raddr_b = w[24:20];
                d.waddr   = w[11:7];
            end
            default: begin
                bad = 1'b1;
            end
        endcase
        // Unused register fields are already zero, so only addresses actually in use are tested.
        bad = bad || ((RV32E != 0) &&
                      ((d.req_ra && d.raddr_a[4]) || (d.req_rb && d.raddr_b[4]) || d.waddr[4]));
        if (bad) begin
            d         = '0;
            d.illegal = 1'b1;
        end else begin
            d.illegal = 1'b0;
        end
        return d;
    endfunction

    // Handshake, FIFO steering and the word presented to the decoder.
    always_comb begin
        ready_s      = rst_ni && !flush_i && (count_r < CNT_FULL);
        push_s       = instr_valid_i && ready_s;
        load_s       = !dec_valid_r || dec_ready_i;
        head_avail_s = (count_r != '0);
        fifo_pop_s   = load_s && head_avail_s;
        // An empty FIFO with a free output register lets the incoming word bypass storage.
        fifo_push_s  = push_s && !(load_s && !head_avail_s);
        src_avail_s  = head_avail_s || push_s;
        src_word_s   = head_avail_s ? mem_r[rd_ptr_r] : instr_rdata_i;
        dec_s        = decode_word(src_word_s);
        case ({fifo_push_s, fifo_pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1);
            2'b01:   count_next_s = count_r - CNT_W'(1);
            default: count_next_s = count_r;
        endcase
    end

    // FIFO storage, wrapping pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= 32'h0000_0000;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else if (flush_i) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (fifo_push_s) begin
                mem_r[wr_ptr_r] <= instr_rdata_i;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (fifo_pop_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_next_s;
        end
    end

    // Decoded output register; only reloads when empty or being consumed.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            dec_valid_r <= 1'b0;
            dec_r       <= '0;
        end else if (flush_i) begin
            dec_valid_r <= 1'b0;
            dec_r       <= '0;
        end else if (load_s) begin
            dec_valid_r <= src_avail_s;
            if (src_avail_s) begin
                dec_r <= dec_s;
            end
        end
    end

    assign instr_ready_o      = ready_s;
    assign dec_valid_o        = dec_valid_r;
    assign count_o            = count_r;
    assign imm_o              = dec_r.imm;
    assign req_rf_ra_o        = dec_r.req_ra;
    assign req_rf_rb_o        = dec_r.req_rb;
    assign rf_raddr_a_o       = dec_r.raddr_a;
    assign rf_raddr_b_o       = dec_r.raddr_b;
    assign rf_waddr_o         = dec_r.waddr;
    assign req_alu_o          = dec_r.req_alu;
    assign operateur_alu_o    = dec_r.alu_op;
    assign type_operand_b_o   = dec_r.op_b;
    assign req_pc_alu_o       = dec_r.req_pc;
    assign operateur_pc_alu_o = dec_r.pc_op;
    assign req_data_o         = dec_r.req_data;
    assign we_data_o          = dec_r.we_data;
    assign illegal_o          = dec_r.illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: an RV32I instance and an RV32E instance share one stimulus
// stream; expected decodes are queued on acceptance and compared while held at the output.
module tb_decode_stage;

    typedef struct packed {
        logic        illegal;
        logic        req_ra;
        logic        req_rb;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wa;
        logic        req_alu;
        logic [4:0]  alu;
        logic        opb;
        logic        req_pc;
        logic [1:0]  pc;
        logic        req_data;
        logic        we;
        logic [31:0] imm;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_valid;
    logic [31:0] instr_rdata;
    logic        flush;
    logic        dec_ready;

    logic        instr_ready, dec_valid, req_ra, req_rb, req_alu, op_b, req_pc, req_data, we_data, illegal;
    logic [31:0] imm;
    logic [4:0]  raddr_a, raddr_b, waddr, alu_op;
    logic [1:0]  pc_op, count;

    logic        instr_ready_e, dec_valid_e, req_ra_e, req_rb_e, req_alu_e, op_b_e, req_pc_e;
    logic        req_data_e, we_data_e, illegal_e;
    logic [31:0] imm_e;
    logic [4:0]  raddr_a_e, raddr_b_e, waddr_e, alu_op_e;
    logic [1:0]  pc_op_e, count_e;

    exp_t obs0, obs1;
    exp_t q0[$];
    exp_t q1[$];
    int   checks = 0;
    int   errors = 0;

    logic [31:0] w_a = 32'h0010_0093;
    logic [31:0] w_b = 32'h0020_0113;
    logic [31:0] w_c = 32'h0030_0193;
    logic [6:0]  opc_tab [12] = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03,
                                  7'h23, 7'h13, 7'h33, 7'h73, 7'h0F, 7'h35};

    decode_stage #(.DEPTH(2), .RV32E(0)) dut (
        .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_rdata_i(instr_rdata), .flush_i(flush), .dec_valid_o(dec_valid), .dec_ready_i(dec_ready),
        .imm_o(imm), .req_rf_ra_o(req_ra), .req_rf_rb_o(req_rb), .rf_raddr_a_o(raddr_a),
        .rf_raddr_b_o(raddr_b), .rf_waddr_o(waddr), .req_alu_o(req_alu), .operateur_alu_o(alu_op),
        .type_operand_b_o(op_b), .req_pc_alu_o(req_pc), .operateur_pc_alu_o(pc_op),
        .req_data_o(req_data), .we_data_o(we_data), .illegal_o(illegal), .count_o(count)
    );

    decode_stage #(.DEPTH(2), .RV32E(1)) dut_e (
        .clk_i(clk), .rst_ni(rst_n), .instr_valid_i(instr_valid), .instr_ready_o(instr_ready_e),
        .instr_rdata_i(instr_rdata), .flush_i(flush), .dec_valid_o(dec_valid_e), .dec_ready_i(dec_ready),
        .imm_o(imm_e), .req_rf_ra_o(req_ra_e), .req_rf_rb_o(req_rb_e), .rf_raddr_a_o(raddr_a_e),
        .rf_raddr_b_o(raddr_b_e), .rf_waddr_o(waddr_e), .req_alu_o(req_alu_e), .operateur_alu_o(alu_op_e),
        .type_operand_b_o(op_b_e), .req_pc_alu_o(req_pc_e), .operateur_pc_alu_o(pc_op_e),
        .req_data_o(req_data_e), .we_data_o(we_data_e), .illegal_o(illegal_e), .count_o(count_e)
    );

    assign obs0 = {illegal, req_ra, req_rb, raddr_a, raddr_b, waddr, req_alu, alu_op, op_b,
                   req_pc, pc_op, req_data, we_data, imm};
    assign obs1 = {illegal_e, req_ra_e, req_rb_e, raddr_a_e, raddr_b_e, waddr_e, req_alu_e, alu_op_e,
                   op_b_e, req_pc_e, pc_op_e, req_data_e, we_data_e, imm_e};

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference decoder written from the instruction-set encodings.
    function automatic exp_t model(input logic [31:0] w, input bit e);
        exp_t       x;
        logic [2:0] f3;
        bit         bad;
        x   = '0;
        f3  = w[14:12];
        bad = 1'b0;
        case (w[6:0])
            7'h37: begin x.req_alu = 1; x.alu = 5'b11000; x.opb = 1; x.wa = w[11:7];
                         x.imm = {w[31:12], 12'h000}; end
            7'h17: begin x.req_pc = 1; x.pc = 2'b11; x.wa = w[11:7]; x.imm = {w[31:12], 12'h000}; end
            7'h6F: begin x.req_pc = 1; x.pc = 2'b00; x.wa = w[11:7];
                         x.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0}; end
            7'h67: begin bad = (f3 != 3'd0); x.req_pc = 1; x.pc = 2'b01; x.req_ra = 1; x.ra = w[19:15];
                         x.wa = w[11:7]; x.imm = {{21{w[31]}}, w[30:20]}; end
            7'h63: begin bad = (f3 == 3'd2) || (f3 == 3'd3); x.req_pc = 1; x.pc = 2'b10; x.req_alu = 1;
                         x.alu = {2'b10, f3}; x.req_ra = 1; x.req_rb = 1; x.ra = w[19:15]; x.rb = w[24:20];
                         x.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0}; end
            7'h03: begin bad = (f3 inside {3'd3, 3'd6, 3'd7}); x.req_data = 1; x.req_alu = 1; x.opb = 1;
                         x.req_ra = 1; x.ra = w[19:15]; x.wa = w[11:7]; x.imm = {{21{w[31]}}, w[30:20]}; end
            7'h23: begin bad = (f3 > 3'd2); x.req_data = 1; x.we = 1; x.req_alu = 1; x.opb = 1;
                         x.req_ra = 1; x.req_rb = 1; x.ra = w[19:15]; x.rb = w[24:20];
                         x.imm = {{21{w[31]}}, w[30:25], w[11:7]}; end
            7'h13: begin x.req_alu = 1; x.alu = {1'b0, (f3 == 3'd5) ? w[30] : 1'b0, f3}; x.opb = 1;
                         x.req_ra = 1; x.ra = w[19:15]; x.wa = w[11:7]; x.imm = {{21{w[31]}}, w[30:20]}; end
            7'h33: begin x.req_alu = 1; x.alu = {1'b0, w[30], f3}; x.req_ra = 1; x.req_rb = 1;
                         x.ra = w[19:15]; x.rb = w[24:20]; x.wa = w[11:7]; end
            default: bad = 1'b1;
        endcase
        if (e && ((x.req_ra && x.ra >= 5'd16) || (x.req_rb && x.rb >= 5'd16) || x.wa >= 5'd16)) bad = 1'b1;
        if (bad) begin
            x         = '0;
            x.illegal = 1'b1;
        end
        return x;
    endfunction

    // Scoreboard: check flow state and held fields on every falling edge, then pop/push.
    always @(negedge clk) begin
        int   exp_count;
        bit   exp_ready;
        exp_t e0;
        exp_t e1;
        if (!rst_n) begin
            q0.delete();
            q1.delete();
            chk("rst_valid", 64'(dec_valid), 64'd0);
            chk("rst_count", 64'(count), 64'd0);
            chk("rst_ready", 64'(instr_ready), 64'd0);
            chk("rst_fields", 64'(obs0), 64'd0);
        end else begin
            exp_count = (q0.size() > 0) ? q0.size() - 1 : 0;
            exp_ready = !flush && (exp_count < 2);
            chk("count", 64'(count), 64'(exp_count));
            chk("ready", 64'(instr_ready), 64'(exp_ready));
            chk("dec_valid", 64'(dec_valid), 64'(q0.size() > 0));
            chk("e_count", 64'(count_e), 64'(exp_count));
            chk("e_dec_valid", 64'(dec_valid_e), 64'(q1.size() > 0));
            if (q0.size() > 0 && dec_valid) begin
                e0 = q0[0];
                e1 = q1[0];
                chk("imm", 64'(obs0.imm), 64'(e0.imm));
                chk("ctrl", 64'(obs0[61:32]), 64'(e0[61:32]));
                chk("e_imm", 64'(obs1.imm), 64'(e1.imm));
                chk("e_ctrl", 64'(obs1[61:32]), 64'(e1[61:32]));
                if (dec_ready) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end
            if (flush) begin
                q0.delete();
                q1.delete();
            end else if (instr_valid && exp_ready) begin
                q0.push_back(model(instr_rdata, 1'b0));
                q1.push_back(model(instr_rdata, 1'b1));
            end
        end
    end

    task automatic send(input logic [31:0] w);
        bit acc;
        acc         = 1'b0;
        instr_valid = 1'b1;
        instr_rdata = w;
        for (int i = 0; i < 20 && !acc; i++) begin
            @(negedge clk);
            acc = instr_ready;
            @(posedge clk);
            #1;
        end
        if (!acc) chk("send_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] w;
        rst_n = 1'b0; instr_valid = 1'b0; instr_rdata = 32'h0; flush = 1'b0; dec_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        dec_ready = 1'b1;
        send(32'h0080_00EF);
        instr_valid = 1'b0;
        chk("jal_valid", 64'(dec_valid), 64'd1);
        chk("jal_pc", 64'(pc_op), 64'd0);
        chk("jal_req_pc", 64'(req_pc), 64'd1);
        chk("jal_rd", 64'(waddr), 64'd1);
        chk("jal_imm", 64'(imm), 64'd8);

        send(32'hFE20_9EE3);
        instr_valid = 1'b0;
        chk("bne_pc", 64'(pc_op), 64'd2);
        chk("bne_alu", 64'(alu_op), 64'h11);
        chk("bne_ra", 64'(raddr_a), 64'd1);
        chk("bne_rb", 64'(raddr_b), 64'd2);
        chk("bne_imm", 64'(imm), 64'h0000_0000_FFFF_FFFC);

        send(32'h0000_2063);
        instr_valid = 1'b0;
        chk("br010_illegal", 64'(illegal), 64'd1);
        chk("br010_reqs", 64'({req_ra, req_rb, req_alu, req_pc, req_data, we_data}), 64'd0);

        send(32'h0000_0833);
        instr_valid = 1'b0;
        chk("add16_legal", 64'(illegal), 64'd0);
        chk("add16_rd", 64'(waddr), 64'd16);
        chk("e_add16_illegal", 64'(illegal_e), 64'd1);
        chk("e_add16_reqs", 64'({req_ra_e, req_rb_e, req_alu_e, req_pc_e, req_data_e, we_data_e}), 64'd0);
        chk("e_add16_rd", 64'(waddr_e), 64'd0);
        @(posedge clk);
        #1;

        dec_ready = 1'b0;
        send(w_a); send(w_b); send(w_c);
        instr_valid = 1'b0;
        chk("bp_count", 64'(count), 64'd2);
        chk("bp_ready", 64'(instr_ready), 64'd0);
        chk("bp_head", 64'(imm), 64'd1);
        dec_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_second", 64'(imm), 64'd2);
        chk("bp_count1", 64'(count), 64'd1);
        @(posedge clk); #1;
        chk("bp_third", 64'(imm), 64'd3);
        chk("bp_count0", 64'(count), 64'd0);
        @(posedge clk); #1;
        chk("bp_empty", 64'(dec_valid), 64'd0);

        dec_ready = 1'b0;
        send(w_a); send(w_b); send(w_c);
        instr_valid = 1'b1;
        instr_rdata = 32'h0040_0213;
        flush       = 1'b1;
        #1;
        chk("fl_ready", 64'(instr_ready), 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        instr_valid = 1'b0;
        chk("fl_count", 64'(count), 64'd0);
        chk("fl_valid", 64'(dec_valid), 64'd0);
        dec_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("fl_dropped", 64'(dec_valid), 64'd0);
        end

        dec_ready = 1'b0;
        send(w_a); send(w_b); send(w_c);
        instr_valid = 1'b0;
        chk("mr_pre_count", 64'(count), 64'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mr_valid", 64'(dec_valid), 64'd0);
        chk("mr_count", 64'(count), 64'd0);
        chk("mr_imm", 64'(imm), 64'd0);
        chk("mr_ready", 64'(instr_ready), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        dec_ready = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            chk("mr_after_valid", 64'(dec_valid), 64'd0);
        end

        for (int c = 0; c < 400; c++) begin
            w = $urandom;
            w[6:0] = opc_tab[$urandom_range(0, 11)];
            instr_valid = ($urandom_range(0, 3) != 0);
            instr_rdata = w;
            dec_ready   = ($urandom_range(0, 2) != 0);
            flush       = ($urandom_range(0, 39) == 0);
            @(posedge clk); #1;
        end
        flush = 1'b0;
        instr_valid = 1'b0;
        dec_ready = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        chk("drain", 64'(q0.size()), 64'd0);
        chk("drain_valid", 64'(dec_valid), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
